// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-port arbiter.
// Holds the arbiter state encoding and the grant index width rule.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first request at or above the pointer.
// Purely combinational; wraps modulo N_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_cand [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_cand
    assign w_cand[k] = IW'((32'(i_ptr) + k) % N_REQ);
  end

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_idx = w_cand[k];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO push port among N_REQ packet requesters.
// Grant is locked per packet; a beat watchdog forces release.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BEATS = 16,
  localparam int IW = id_width(N_REQ)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [N_REQ-1:0]        s_valid,
  input  logic [N_REQ-1:0]        s_last,
  input  logic [N_REQ*DWIDTH-1:0] s_data,
  output logic [N_REQ-1:0]        s_ready,
  output logic                    push,
  output logic [DWIDTH-1:0]       push_data,
  input  logic                    full,
  output logic                    busy,
  output logic [IW-1:0]           grant_id,
  output logic                    err_overlong
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  arb_state_e    r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_grant_id;
  logic [CW-1:0] r_beat_cnt;
  logic          r_err;

  logic [IW-1:0]     w_win;
  logic              w_any;
  logic              w_xfer;
  logic              w_accept;
  logic              w_last;
  logic              w_force;
  logic [CW-1:0]     w_cnt_nxt;
  logic [IW-1:0]     w_ptr_nxt;
  logic [DWIDTH-1:0] w_data [N_REQ];

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req (s_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_data
    assign w_data[i] = s_data[i*DWIDTH +: DWIDTH];
  end

  assign w_xfer    = (r_state == XFER);
  assign w_accept  = w_xfer & s_valid[r_grant_id] & ~full;
  assign w_cnt_nxt = r_beat_cnt + CW'(1);
  assign w_last    = w_accept & s_last[r_grant_id];
  assign w_force   = w_accept & ~s_last[r_grant_id]
                   & (w_cnt_nxt == CW'(MAX_BEATS));
  assign w_ptr_nxt = (r_grant_id == IW'(N_REQ - 1))
                   ? '0 : r_grant_id + IW'(1);

  always_comb begin
    s_ready = '0;
    if (w_xfer) s_ready[r_grant_id] = ~full;
  end

  assign push         = w_accept;
  assign push_data    = w_data[r_grant_id];
  assign busy         = w_xfer;
  assign grant_id     = r_grant_id;
  assign err_overlong = r_err;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_force;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_id <= w_win;
            r_beat_cnt <= '0;
            r_state    <= XFER;
          end
        end
        XFER: begin
          if (w_accept) r_beat_cnt <= w_cnt_nxt;
          if (w_last || w_force) begin
            r_rr_ptr <= w_ptr_nxt;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter (N_REQ=4, MAX_BEATS=4).
// Inputs change on negedge; outputs sampled 1 ns later.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_last;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]  s_ready;
  logic          push;
  logic [DW-1:0] push_data;
  logic          full;
  logic          busy;
  logic [1:0]    grant_id;
  logic          err_overlong;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_push_arbiter #(
    .N_REQ(N), .DWIDTH(DW), .MAX_BEATS(4)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .push         (push),
    .push_data    (push_data),
    .full         (full),
    .busy         (busy),
    .grant_id     (grant_id),
    .err_overlong (err_overlong)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
    #1;
  endtask

  task automatic set_d(input int i, input logic [31:0] v);
    s_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    full = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    #1;
  endtask

  task automatic beat(input string tag, input logic [31:0] d);
    chk({tag, " push"}, 32'(push), 32'd1);
    chk({tag, " data"}, push_data, d);
    step();
  endtask

  initial begin
    areset = 1'b1;
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    full = 1'b0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst gid", 32'(grant_id), 32'd0);
    chk("rst push", 32'(push), 32'd0);
    chk("rst rdy", 32'(s_ready), 32'd0);
    chk("rst err", 32'(err_overlong), 32'd0);

    // T1: requester 2, 3 beats
    do_reset();
    s_valid = 4'b0100;
    set_d(2, 32'h10);
    #1;
    chk("t1 idle push", 32'(push), 32'd0);
    chk("t1 idle rdy", 32'(s_ready), 32'd0);
    step();
    chk("t1 busy", 32'(busy), 32'd1);
    chk("t1 gid", 32'(grant_id), 32'd2);
    chk("t1 rdy", 32'(s_ready), 32'h4);
    beat("t1 b1", 32'h10);
    set_d(2, 32'h11);
    #1;
    beat("t1 b2", 32'h11);
    set_d(2, 32'h12);
    s_last = 4'b0100;
    #1;
    beat("t1 b3", 32'h12);
    s_valid = 4'b0000;
    s_last = 4'b0000;
    #1;
    chk("t1 done busy", 32'(busy), 32'd0);
    chk("t1 gid hold", 32'(grant_id), 32'd2);
    s_valid = 4'b1010;
    s_last = 4'b1010;
    step();
    chk("t1 ptr3 win", 32'(grant_id), 32'd3);
    step();

    // T2: all four, 1-beat packets
    do_reset();
    s_valid = 4'b1111;
    s_last = 4'b1111;
    for (int i = 0; i < N; i++) set_d(i, 32'hA0 + i);
    #1;
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      foreach (order[k]) begin
        chk("t2 gap push", 32'(push), 32'd0);
        chk("t2 gap busy", 32'(busy), 32'd0);
        step();
        chk("t2 gid", 32'(grant_id), 32'(order[k]));
        beat("t2", 32'hA0 + order[k]);
      end
    end
    s_valid = '0;
    s_last = '0;

    // T3: requester 1 stalled by full for 5 cycles
    do_reset();
    s_valid = 4'b0010;
    set_d(1, 32'h20);
    step();
    beat("t3 b1", 32'h20);
    set_d(1, 32'h21);
    full = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t3 stall push", 32'(push), 32'd0);
      chk("t3 stall rdy", 32'(s_ready), 32'd0);
      chk("t3 stall gid", 32'(grant_id), 32'd1);
      chk("t3 stall busy", 32'(busy), 32'd1);
      step();
    end
    full = 1'b0;
    #1;
    chk("t3 rdy", 32'(s_ready), 32'h2);
    beat("t3 b2", 32'h21);
    set_d(1, 32'h22);
    s_last = 4'b0010;
    #1;
    beat("t3 b3", 32'h22);
    s_valid = '0;
    s_last = '0;
    #1;
    chk("t3 end busy", 32'(busy), 32'd0);
    chk("t3 no err", 32'(err_overlong), 32'd0);

    // T4: overlong from requester 0, requester 3 waiting
    do_reset();
    s_valid = 4'b1001;
    s_last = 4'b1000;
    set_d(3, 32'h3F);
    set_d(0, 32'h30);
    #1;
    step();
    chk("t4 gid0", 32'(grant_id), 32'd0);
    for (int b = 0; b < 4; b++) begin
      set_d(0, 32'h30 + b);
      #1;
      chk("t4 err low", 32'(err_overlong), 32'd0);
      beat("t4 first", 32'h30 + b);
    end
    set_d(0, 32'h34);
    #1;
    chk("t4 err pulse", 32'(err_overlong), 32'd1);
    chk("t4 rel busy", 32'(busy), 32'd0);
    step();
    chk("t4 err once", 32'(err_overlong), 32'd0);
    chk("t4 gid3", 32'(grant_id), 32'd3);
    beat("t4 r3", 32'h3F);
    s_valid = 4'b0001;
    s_last = 4'b0000;
    #1;
    chk("t4 gap busy", 32'(busy), 32'd0);
    step();
    chk("t4 gid0 again", 32'(grant_id), 32'd0);
    beat("t4 b5", 32'h34);
    set_d(0, 32'h35);
    s_last = 4'b0001;
    #1;
    beat("t4 b6", 32'h35);
    s_valid = '0;
    s_last = '0;
    #1;
    chk("t4 end busy", 32'(busy), 32'd0);
    chk("t4 end err", 32'(err_overlong), 32'd0);

    // T5: reset mid-packet, pointer returns to 0
    do_reset();
    s_valid = 4'b0010;
    s_last = 4'b0010;
    set_d(1, 32'h51);
    step();
    beat("t5 r1", 32'h51);
    s_valid = 4'b0100;
    s_last = 4'b0000;
    set_d(2, 32'h60);
    step();
    chk("t5 gid2", 32'(grant_id), 32'd2);
    beat("t5 b1", 32'h60);
    set_d(2, 32'h61);
    #1;
    beat("t5 b2", 32'h61);
    s_valid = 4'b0101;
    areset = 1'b1;
    #1;
    chk("t5 rst push", 32'(push), 32'd0);
    chk("t5 rst rdy", 32'(s_ready), 32'd0);
    chk("t5 rst busy", 32'(busy), 32'd0);
    chk("t5 rst gid", 32'(grant_id), 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    step();
    chk("t5 win0", 32'(grant_id), 32'd0);
    chk("t5 busy", 32'(busy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
